alu36: RTL and testbench

// - 36-bit registered integer ALU for the datapath execute stage: two operands and a 3-bit op select in, result and status flags out.
// - One cycle of latency.
// - Wraps at 36 bits. Overflow does not trap; it is reported through the flags.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_addsub.sv | 16 +
 rtl/alu36.sv | 69 ++++++
 tb/tb_alu36.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and operation codes for the alu36 datapath
package alu_pkg;
    localparam int DATA_WIDTH   = 36;
    localparam int ALU_OP_WIDTH = 3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 3'b100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT = 3'b101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 3'b110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 3'b111;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational adder/subtractor (a + b or a + ~b + 1) with carry and signed overflow
module alu_addsub #(
    parameter int DATA_WIDTH = 36
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry,
    output logic                  overflow
);
    logic [DATA_WIDTH-1:0] bx;
    assign bx = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, bx} + {{DATA_WIDTH{1'b0}}, sub};
    assign overflow = (a[DATA_WIDTH-1] == bx[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
endmodule

// File: rtl/alu36.sv
// alu36: registered 36-bit integer ALU with zero/negative/carry/overflow flags, one cycle latency
module alu36 #(
    parameter int DATA_WIDTH   = alu_pkg::DATA_WIDTH,
    parameter int ALU_OP_WIDTH = alu_pkg::ALU_OP_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    input  logic [ALU_OP_WIDTH-1:0] i_ALUControlS,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_ALU_Result,
    output logic                    o_zero,
    output logic                    o_negative,
    output logic                    o_carry,
    output logic                    o_overflow
);
    import alu_pkg::*;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] res;
    logic                  cout;
    logic                  ovf;
    logic                  arith;
    logic                  lt;
    logic [5:0]            sh;
    assign sh = i_b[5:0];
    // SLT reuses the subtractor: signed a<b is the difference's sign corrected by overflow
    alu_addsub #(.DATA_WIDTH(DATA_WIDTH)) u_addsub (
        .a        (i_a),
        .b        (i_b),
        .sub      (i_ALUControlS != ALU_ADD),
        .sum      (sum),
        .carry    (cout),
        .overflow (ovf)
    );
    // Operation mux; shifts of DATA_WIDTH or more fall off the end and give 0
    always_comb begin
        arith = i_ALUControlS == ALU_ADD || i_ALUControlS == ALU_SUB;
        lt    = sum[DATA_WIDTH-1] ^ ovf;
        res   = arith                         ? sum :
                i_ALUControlS == ALU_AND      ? i_a & i_b :
                i_ALUControlS == ALU_OR       ? i_a | i_b :
                i_ALUControlS == ALU_XOR      ? i_a ^ i_b :
                i_ALUControlS == ALU_SLT      ? {{(DATA_WIDTH-1){1'b0}}, lt} :
                i_ALUControlS == ALU_SLL      ? i_a << sh :
                                                i_a >> sh;
    end
    // Output register: reset wins, idle cycles hold result and flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_ALU_Result <= '0;
            o_zero       <= 1'b0;
            o_negative   <= 1'b0;
            o_carry      <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_ALU_Result <= res;
                o_zero       <= res == '0;
                o_negative   <= res[DATA_WIDTH-1];
                o_carry      <= arith & cout;
                o_overflow   <= arith & ovf;
            end
        end
    end
endmodule

// File: tb/tb_alu36.sv
// tb_alu36: directed vector table, reset/hold sequences and randomized checks against a reference model
module tb_alu36;
    import alu_pkg::*;
    localparam int W = 36;
    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         o_valid;
    logic [W-1:0] o_res;
    logic         o_zero;
    logic         o_negative;
    logic         o_carry;
    logic         o_overflow;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } vec_t;

    vec_t tbl[$];
    vec_t e;
    vec_t zv;
    logic ev;

    alu36 dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .i_a           (a),
        .i_b           (b),
        .i_ALUControlS (op),
        .o_valid       (o_valid),
        .o_ALU_Result  (o_res),
        .o_zero        (o_zero),
        .o_negative    (o_negative),
        .o_carry       (o_carry),
        .o_overflow    (o_overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t m;
        logic [63:0] ua, ub, full;
        longint sa, sb, st, smax, smin;
        ua   = 64'(x);
        ub   = 64'(y);
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        sa   = x[W-1] ? longint'(ua) - (longint'(1) <<< W) : longint'(ua);
        sb   = y[W-1] ? longint'(ub) - (longint'(1) <<< W) : longint'(ub);
        m    = '{o, x, y, '0, 1'b0, 1'b0, 1'b0, 1'b0};
        st   = 0;
        full = '0;
        case (o)
            ALU_ADD: begin full = ua + ub; st = sa + sb; m.c = full[W]; end
            ALU_SUB: begin full = ua - ub; st = sa - sb; m.c = ua >= ub; end
            ALU_AND: full = ua & ub;
            ALU_OR:  full = ua | ub;
            ALU_XOR: full = ua ^ ub;
            ALU_SLT: full = (sa < sb) ? 64'd1 : 64'd0;
            ALU_SLL: full = (int'(ub[5:0]) >= W) ? 64'd0 : ua << ub[5:0];
            default: full = (int'(ub[5:0]) >= W) ? 64'd0 : ua >> ub[5:0];
        endcase
        m.r = full[W-1:0];
        m.v = (o == ALU_ADD || o == ALU_SUB) && (st > smax || st < smin);
        m.z = m.r == '0;
        m.n = m.r[W-1];
        return m;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [63:0] t;
        t = {$urandom, $urandom};
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return 36'h7_FFFF_FFFF;
            3: return 36'h8_0000_0000;
            4: return W'($urandom_range(0, 70));
            default: return t[W-1:0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic exp_v, input vec_t x);
        chk({tag, ".valid"}, 64'(o_valid), 64'(exp_v));
        chk({tag, ".result"}, 64'(o_res), 64'(x.r));
        chk({tag, ".zero"}, 64'(o_zero), 64'(x.z));
        chk({tag, ".negative"}, 64'(o_negative), 64'(x.n));
        chk({tag, ".carry"}, 64'(o_carry), 64'(x.c));
        chk({tag, ".overflow"}, 64'(o_overflow), 64'(x.v));
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        rst   = r;
        valid = v;
        op    = o;
        a     = x;
        b     = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        zv = '{3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl.push_back('{ALU_ADD, 36'd1, 36'd1, 36'd2, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_ADD, 36'd435, 36'd245, 36'h2A8, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_SUB, 36'd2, 36'd1, 36'd1, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{ALU_SUB, 36'd5, 36'd6, 36'hF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{ALU_AND, 36'd2, 36'd7, 36'd2, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_OR, 36'd8, 36'd11, 36'hB, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_XOR, 36'd8, 36'd11, 36'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_ADD, 36'hF_FFFF_FFFF, 36'd1, 36'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{ALU_ADD, 36'h7_FFFF_FFFF, 36'd1, 36'h8_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{ALU_SLT, 36'hF_FFFF_FFFF, 36'd1, 36'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_SLT, 36'd1, 36'hF_FFFF_FFFF, 36'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_SLL, 36'd1, 36'd35, 36'h8_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{ALU_SLL, 36'd1, 36'd36, 36'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_SRL, 36'hF_FFFF_FFFF, 36'd36, 36'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_SRL, 36'h8_0000_0000, 36'd35, 36'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{ALU_SUB, 36'd3, 36'd3, 36'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{ALU_SUB, 36'h8_0000_0000, 36'd1, 36'h7_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1});
        rst   = 1'b1;
        valid = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, zv);
        drive(1'b0, 1'b0, ALU_ADD, 36'd9, 36'd9);
        step();
        chk_out("idle", 1'b0, zv);
        drive(1'b0, 1'b1, ALU_ADD, 36'd1, 36'd1);
        #1;
        chk("latency.before_edge", 64'(o_valid), 64'd0);
        step();
        chk("latency.after_edge", 64'(o_valid), 64'd1);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(1'b0, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
            step();
            chk_out($sformatf("vec%0d", i), 1'b1, tbl[i]);
            e = tbl[i];
        end
        drive(1'b0, 1'b0, ALU_ADD, 36'd5, 36'd5);
        step();
        chk_out("hold", 1'b0, e);
        drive(1'b0, 1'b1, ALU_ADD, 36'd3, 36'd4);
        step();
        e = '{ALU_ADD, 36'd3, 36'd4, 36'd7, 1'b0, 1'b0, 1'b0, 1'b0};
        chk_out("pre_rst", 1'b1, e);
        drive(1'b1, 1'b1, ALU_SUB, 36'd5, 36'd6);
        step();
        chk_out("rst_mid", 1'b0, zv);
        drive(1'b0, 1'b0, ALU_SUB, 36'd5, 36'd6);
        step();
        chk_out("post_rst_hold", 1'b0, zv);
        e = zv;
        for (int i = 0; i < 400; i++) begin
            logic         r, v;
            logic [2:0]   o;
            logic [W-1:0] x, y;
            r = $urandom_range(0, 39) == 0;
            v = $urandom_range(0, 3) != 0;
            o = 3'($urandom);
            x = pick();
            y = pick();
            drive(r, v, o, x, y);
            step();
            if (r) begin
                e  = zv;
                ev = 1'b0;
            end else begin
                ev = v;
                if (v) e = model(o, x, y);
            end
            chk_out($sformatf("rand%0d", i), ev, e);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
